imem_fetch_responder: RTL

- Responder side of the F2 instruction-fetch interface.
- Accepts the 10-bit byte address driven out of the F2 pipeline register and returns a 64-bit two-instruction bundle {inst @addr+4, inst @addr}.
- Raises a stall toward the pipeline whenever that bundle is not yet available.
- Fills a one-pair line buffer from a 32-bit, variable-latency, req/ack backing instruction memory, two beats per pair.

---
 rtl/imem_fetch_responder_pkg.sv | 18 +
 rtl/imem_pair_buffer.sv | 66 ++++++
 rtl/imem_fetch_responder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_responder_pkg.sv
// rtl/imem_fetch_responder_pkg.sv - shared types and constants for the F2 instruction-fetch responder
// Purpose: FSM state encoding, byte-to-word offset and default fetch address width.
// Ports: none (package).
package imem_fetch_responder_pkg;

    localparam int IMEM_IADDR_W      = 10;
    localparam int IMEM_WORD_OFFSET  = 4;
    localparam int IMEM_WORD_SHIFT   = $clog2(IMEM_WORD_OFFSET);

    typedef enum logic [2:0] {
        IMEM_IDLE   = 3'd0,
        IMEM_FETCH0 = 3'd1,
        IMEM_FETCH1 = 3'd2,
        IMEM_PRE0   = 3'd3,
        IMEM_PRE1   = 3'd4
    } imem_state_e;

endpackage

// File: rtl/imem_pair_buffer.sv
// rtl/imem_pair_buffer.sv - one instruction-pair line: tag, valid and two 32-bit words with tag compare
// Purpose: stores one fetched pair {word1, word0} tagged by the word address of word0.
// Ports:
//   clock, reset        : clock, asynchronous active-high reset
//   clear               : drop valid (wins over set_valid/load)
//   wr0_en, wr1_en      : write wr_data into word0 / word1 (wr1 also records wr_tag)
//   set_valid           : mark the pair valid after the second beat
//   load_en, load_*     : load a complete pair in one cycle (promotion from another buffer)
//   lookup, match       : compare a word address against the stored tag
//   tag, valid, word0/1 : stored state
module imem_pair_buffer
    import imem_fetch_responder_pkg::*;
#(
    parameter int WADDR_W = IMEM_IADDR_W - IMEM_WORD_SHIFT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               wr0_en,
    input  logic               wr1_en,
    input  logic [31:0]        wr_data,
    input  logic [WADDR_W-1:0] wr_tag,
    input  logic               set_valid,
    input  logic               load_en,
    input  logic [WADDR_W-1:0] load_tag,
    input  logic [31:0]        load_word0,
    input  logic [31:0]        load_word1,
    input  logic [WADDR_W-1:0] lookup,
    output logic               match,
    output logic [WADDR_W-1:0] tag,
    output logic               valid,
    output logic [31:0]        word0,
    output logic [31:0]        word1
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag   <= '0;
            valid <= 1'b0;
            word0 <= '0;
            word1 <= '0;
        end else begin
            if (load_en) begin
                tag   <= load_tag;
                word0 <= load_word0;
                word1 <= load_word1;
            end
            if (wr0_en) begin
                word0 <= wr_data;
            end
            if (wr1_en) begin
                word1 <= wr_data;
                tag   <= wr_tag;
            end
            // A flush in the same cycle as the final beat must leave the pair invalid.
            if (clear) begin
                valid <= 1'b0;
            end else if (load_en || set_valid) begin
                valid <= 1'b1;
            end
        end
    end

    assign match = valid && (tag == lookup);

endmodule

// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - F2 fetch responder returning a 64-bit instruction pair from a 32-bit req/ack memory
// Purpose: serves {inst@addr+4, inst@addr} from a one-pair line buffer, stalls F2 on a miss and
//          fills the pair with two back-to-back beats while holding mem_req_o high.
//          Optional macro IMEM_PREFETCH_EN adds a speculative next-pair buffer (tag+2).
// Ports:
//   clock_i, reset_i      : clock, asynchronous active-high reset
//   iaddr_i               : byte fetch address from F2 (bits [1:0] ignored)
//   flush_i               : invalidate buffered pair(s)
//   idata_o               : {word1, word0}, registered source
//   stall_o               : high when idata_o is not valid for iaddr_i
//   mem_req_o, mem_addr_o : backing-memory read request and word address
//   mem_ack_i, mem_rdata_i: backing-memory beat acknowledge and data
module imem_fetch_responder
    import imem_fetch_responder_pkg::*;
#(
    parameter int IADDR_W = IMEM_IADDR_W,
    parameter int WADDR_W = IADDR_W - 2
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [IADDR_W-1:0] iaddr_i,
    input  logic               flush_i,
    output logic [63:0]        idata_o,
    output logic               stall_o,
    output logic               mem_req_o,
    output logic [WADDR_W-1:0] mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [31:0]        mem_rdata_i
);

    logic [WADDR_W-1:0] req_word;
    assign req_word = iaddr_i[IADDR_W-1:IMEM_WORD_SHIFT];

    imem_state_e        state_r, state_n;
    logic [WADDR_W-1:0] fa_r, fa_n;
    logic [WADDR_W-1:0] addr_n;
    logic               req_n;
    logic               discard_r, discard_n;

    logic               p_clear, p_wr0, p_wr1, p_set, p_load;
    logic               p_match, p_valid;
    logic [WADDR_W-1:0] p_tag;
    logic [31:0]        p_word0, p_word1;
    logic               hit_pri, hit;

    assign hit_pri = p_match && !flush_i;

`ifdef IMEM_PREFETCH_EN
    logic               n_clear, n_wr0, n_wr1, n_set;
    logic               n_match, n_valid;
    logic [WADDR_W-1:0] n_tag;
    logic [31:0]        n_word0, n_word1;
    logic               next_hit;
    logic               unused_bits;

    assign unused_bits = ^iaddr_i[IMEM_WORD_SHIFT-1:0];

    // Promotion only happens from IDLE so a fill in progress never has its target overwritten.
    assign next_hit = n_match && !flush_i && (state_r == IMEM_IDLE);
    assign hit      = hit_pri || next_hit;
    assign idata_o  = next_hit ? {n_word1, n_word0} : {p_word1, p_word0};

    imem_pair_buffer #(.WADDR_W(WADDR_W)) u_next (
        .clock      (clock_i),
        .reset      (reset_i),
        .clear      (n_clear),
        .wr0_en     (n_wr0),
        .wr1_en     (n_wr1),
        .wr_data    (mem_rdata_i),
        .wr_tag     (fa_r),
        .set_valid  (n_set),
        .load_en    (1'b0),
        .load_tag   ('0),
        .load_word0 ('0),
        .load_word1 ('0),
        .lookup     (req_word),
        .match      (n_match),
        .tag        (n_tag),
        .valid      (n_valid),
        .word0      (n_word0),
        .word1      (n_word1)
    );
`else
    logic unused_bits;

    assign unused_bits = ^{iaddr_i[IMEM_WORD_SHIFT-1:0], p_tag, p_valid, p_load};
    assign hit     = hit_pri;
    assign idata_o = {p_word1, p_word0};
`endif

    assign stall_o = !hit;

    imem_pair_buffer #(.WADDR_W(WADDR_W)) u_pri (
        .clock      (clock_i),
        .reset      (reset_i),
        .clear      (p_clear),
        .wr0_en     (p_wr0),
        .wr1_en     (p_wr1),
        .wr_data    (mem_rdata_i),
        .wr_tag     (fa_r),
        .set_valid  (p_set),
`ifdef IMEM_PREFETCH_EN
        .load_en    (p_load),
        .load_tag   (n_tag),
        .load_word0 (n_word0),
        .load_word1 (n_word1),
`else
        .load_en    (1'b0),
        .load_tag   ('0),
        .load_word0 ('0),
        .load_word1 ('0),
`endif
        .lookup     (req_word),
        .match      (p_match),
        .tag        (p_tag),
        .valid      (p_valid),
        .word0      (p_word0),
        .word1      (p_word1)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= IMEM_IDLE;
            fa_r       <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            discard_r  <= 1'b0;
        end else begin
            state_r    <= state_n;
            fa_r       <= fa_n;
            mem_req_o  <= req_n;
            mem_addr_o <= addr_n;
            discard_r  <= discard_n;
        end
    end

    always_comb begin
        state_n   = state_r;
        fa_n      = fa_r;
        addr_n    = mem_addr_o;
        req_n     = mem_req_o;
        discard_n = discard_r;
        p_clear   = 1'b0;
        p_wr0     = 1'b0;
        p_wr1     = 1'b0;
        p_set     = 1'b0;
        p_load    = 1'b0;
`ifdef IMEM_PREFETCH_EN
        n_clear   = 1'b0;
        n_wr0     = 1'b0;
        n_wr1     = 1'b0;
        n_set     = 1'b0;
`endif

        // Flush invalidates everything buffered regardless of state.
        if (flush_i) begin
            p_clear = 1'b1;
`ifdef IMEM_PREFETCH_EN
            n_clear = 1'b1;
`endif
        end

        case (state_r)
            IMEM_IDLE: begin
`ifdef IMEM_PREFETCH_EN
                if (next_hit) begin
                    p_load  = 1'b1;
                    n_clear = 1'b1;
                end else if (!hit_pri) begin
                    fa_n      = req_word;
                    addr_n    = req_word;
                    req_n     = 1'b1;
                    discard_n = 1'b0;
                    p_clear   = 1'b1;
                    state_n   = IMEM_FETCH0;
                end else if (p_valid && !n_valid) begin
                    fa_n      = p_tag + WADDR_W'(2);
                    addr_n    = p_tag + WADDR_W'(2);
                    req_n     = 1'b1;
                    discard_n = 1'b0;
                    state_n   = IMEM_PRE0;
                end
`else
                if (!hit_pri) begin
                    fa_n      = req_word;
                    addr_n    = req_word;
                    req_n     = 1'b1;
                    discard_n = 1'b0;
                    // Invalidate on entry so nothing stale can hit while the pair is rewritten.
                    p_clear   = 1'b1;
                    state_n   = IMEM_FETCH0;
                end
`endif
            end

            IMEM_FETCH0: begin
                if (flush_i) begin
                    discard_n = 1'b1;
                end
                if (mem_ack_i) begin
                    p_wr0   = 1'b1;
                    addr_n  = fa_r + WADDR_W'(1);
                    state_n = IMEM_FETCH1;
                end
            end

            IMEM_FETCH1: begin
                if (flush_i) begin
                    discard_n = 1'b1;
                end
                if (mem_ack_i) begin
                    p_wr1     = 1'b1;
                    p_set     = !discard_r && !flush_i;
                    req_n     = 1'b0;
                    discard_n = 1'b0;
                    state_n   = IMEM_IDLE;
                end
            end

`ifdef IMEM_PREFETCH_EN
            IMEM_PRE0: begin
                if (flush_i) begin
                    discard_n = 1'b1;
                end
                if (mem_ack_i) begin
                    n_wr0   = 1'b1;
                    addr_n  = fa_r + WADDR_W'(1);
                    state_n = IMEM_PRE1;
                end
            end

            IMEM_PRE1: begin
                if (flush_i) begin
                    discard_n = 1'b1;
                end
                if (mem_ack_i) begin
                    n_wr1     = 1'b1;
                    n_set     = !discard_r && !flush_i;
                    req_n     = 1'b0;
                    discard_n = 1'b0;
                    state_n   = IMEM_IDLE;
                end
            end
`endif

            default: begin
                state_n = IMEM_IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

endmodule
